// File: rtl/mem_stage.sv
// Memory-access stage: breaks one load/store into little-endian byte
// transfers on a shared byte-wide RAM port, extends load data and hands
// the write-back triple to MEM/WB. Stalls upstream while an access runs.
module mem_stage #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [2:0]        mem_funct3_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_write_data_i,
  input  logic              mem_grant_i,
  input  logic [7:0]        ram_din_i,
  output logic              ram_req_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_dout_o,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o,
  output logic              stall_req_o
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, XFER, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [31:0]       sdata;
  logic [2:0]        f3;
  logic              we;
  logic [2:0]        k;      // issue count within XFER
  logic [3:0][7:0]   lane;   // captured load bytes, lane i = byte i

  logic              legal;
  logic [2:0]        nb;
  logic              xfer_last;
  logic [31:0]       ld_data;
  logic [31:0]       sshift;

  // Legal loads: LB/LH/LW/LBU/LHU; legal stores: SB/SH/SW. Anything else
  // behaves like a plain ALU op.
  always_comb begin
    legal = 1'b0;
    if (mem_req_i) begin
      if (mem_we_i) legal = !mem_funct3_i[2] && (mem_funct3_i[1:0] != 2'd3);
      else          legal = (mem_funct3_i[1:0] != 2'd3) &&
                            !(mem_funct3_i[2] && mem_funct3_i[1]);
    end
  end

  // Byte count of the latched access, and the last XFER cycle. A load needs
  // one extra cycle to capture the byte addressed in its final issue cycle.
  always_comb begin
    case (f3[1:0])
      2'd0:    nb = 3'd1;
      2'd1:    nb = 3'd2;
      default: nb = 3'd4;
    endcase
    xfer_last = we ? (k == nb - 3'd1) : (k == nb);
  end

  // Access sequencer; reset aborts immediately, already-written bytes stay.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      base  <= '0;
      sdata <= '0;
      f3    <= '0;
      we    <= 1'b0;
      k     <= '0;
      lane  <= '0;
    end else begin
      case (state)
        IDLE: if (legal) begin
          base  <= mem_addr_i[ADDR_W-1:0];
          sdata <= mem_write_data_i;
          f3    <= mem_funct3_i;
          we    <= mem_we_i;
          lane  <= '0;
          state <= WAIT_GNT;
        end
        WAIT_GNT: if (mem_grant_i) begin
          k     <= '0;
          state <= XFER;
        end
        XFER: begin
          k <= k + 3'd1;
          // byte addressed in cycle i arrives in cycle i+1
          for (int i = 0; i < 4; i++)
            if (!we && k == 3'(i + 1)) lane[i] <= ram_din_i;
          if (xfer_last) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Load extension from the captured byte lanes.
  always_comb begin
    case (f3)
      3'd0:    ld_data = {{24{lane[0][7]}}, lane[0]};
      3'd4:    ld_data = {24'd0, lane[0]};
      3'd1:    ld_data = {{16{lane[1][7]}}, lane[1], lane[0]};
      3'd5:    ld_data = {16'd0, lane[1], lane[0]};
      default: ld_data = {lane[3], lane[2], lane[1], lane[0]};
    endcase
  end

  // RAM port drive: address/data only while a byte is being issued.
  always_comb begin
    sshift     = sdata >> {k[1:0], 3'b000};
    ram_req_o  = (state == WAIT_GNT) || (state == XFER);
    ram_wr_o   = (state == XFER) && we;
    ram_addr_o = '0;
    ram_dout_o = '0;
    if (state == XFER && k < nb) ram_addr_o = base + ADDR_W'(k);
    if (ram_wr_o)                ram_dout_o = sshift[7:0];
  end

  // Pipeline side: pass-through when idle, result in DONE, bubble while
  // stalled. Gated by reset so everything reads 0 the moment reset asserts.
  always_comb begin
    stall_req_o = 1'b0;
    wd_o        = '0;
    wreg_o      = 1'b0;
    wdata_o     = '0;
    if (rst) begin
      case (state)
        IDLE: begin
          if (legal) stall_req_o = 1'b1;
          else begin
            wd_o    = wd_i;
            wreg_o  = wreg_i;
            wdata_o = wdata_i;
          end
        end
        WAIT_GNT, XFER: stall_req_o = 1'b1;
        DONE: begin
          wd_o    = wd_i;
          wreg_o  = wreg_i;
          wdata_o = we ? wdata_i : ld_data;
        end
        default: ;
      endcase
    end
  end

endmodule
